// File: rtl/regfile_ctx_stack.sv
`default_nettype none
// ============================================================================
// Module   : regfile_ctx_stack
// Brief    : SimpleRISC register file with a nested interrupt context stack and
//            a save/restore FSM. Define REGFILE_R0_ZERO_EN to hardwire reg 0 to 0.
// Revision : 1.0
// ============================================================================
module regfile_ctx_stack #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int NUM_RD    = 2,
  parameter int CTX_DEPTH = 4,
  parameter int EPC_IDX   = 12,
  parameter int FLAGS_IDX = 13,
  parameter int SP_IDX    = 14,
  parameter int SP_RESET  = 25,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int DW       = $clog2(CTX_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rs,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic [AW-1:0]            rd_ra,
  input  logic                     isWb,
  input  logic [DATA_W-1:0]        data,
  output logic                     wb_stall,
  input  logic                     interrupt,
  input  logic [DATA_W-1:0]        pc_EX,
  input  logic [1:0]               flags,
  input  logic                     Iret,
  output logic                     int_ack,
  output logic                     iret_ack,
  output logic [1:0]               flag_out,
  output logic [DATA_W-1:0]        ret_pc,
  output logic [DW-1:0]            ctx_depth,
  output logic                     ctx_err
);

  localparam int SW = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE_PC = 2'd1,
    ST_SAVE_FL = 2'd2,
    ST_RESTORE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q     [NUM_REGS];
  logic [DATA_W-1:0]   regs_d     [NUM_REGS];
  logic [DATA_W-1:0]   stack_pc_q [CTX_DEPTH];
  logic [DATA_W-1:0]   stack_pc_d [CTX_DEPTH];
  logic [1:0]          stack_fl_q [CTX_DEPTH];
  logic [1:0]          stack_fl_d [CTX_DEPTH];
  logic [DW-1:0]       depth_q, depth_d;
  logic                int_pend_q, int_pend_d;
  logic                iret_pend_q, iret_pend_d;
  logic [DATA_W-1:0]   pend_pc_q, pend_pc_d;
  logic [1:0]          pend_fl_q, pend_fl_d;
  logic [1:0]          flag_out_q, flag_out_d;
  logic [DATA_W-1:0]   ret_pc_q, ret_pc_d;
  logic                ctx_err_q, ctx_err_d;

  logic [SW-1:0]       w_top_idx;
  logic [SW-1:0]       w_push_idx;
  logic                w_full;
  logic                w_empty;
  logic                w_fsm_we;
  logic [AW-1:0]       w_fsm_addr;
  logic [DATA_W-1:0]   w_fsm_data;
  logic                w_we;
  logic [AW-1:0]       w_waddr;
  logic [DATA_W-1:0]   w_wdata;

  assign w_top_idx  = SW'(depth_q - DW'(1));
  assign w_push_idx = SW'(depth_q);
  assign w_full     = (depth_q == DW'(CTX_DEPTH));
  assign w_empty    = (depth_q == '0);

  assign wb_stall  = (state_q == ST_SAVE_PC) || (state_q == ST_SAVE_FL);
  assign int_ack   = (state_q == ST_SAVE_FL);
  assign iret_ack  = (state_q == ST_RESTORE);
  assign flag_out  = flag_out_q;
  assign ret_pc    = ret_pc_q;
  assign ctx_depth = depth_q;
  assign ctx_err   = ctx_err_q;

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    stack_pc_d  = stack_pc_q;
    stack_fl_d  = stack_fl_q;
    int_pend_d  = int_pend_q;
    iret_pend_d = iret_pend_q;
    pend_pc_d   = pend_pc_q;
    pend_fl_d   = pend_fl_q;
    flag_out_d  = flag_out_q;
    ret_pc_d    = ret_pc_q;
    ctx_err_d   = ctx_err_q;
    w_fsm_we    = 1'b0;
    w_fsm_addr  = '0;
    w_fsm_data  = '0;

    case (state_q)
      ST_IDLE: begin
        if (int_pend_q) begin
          int_pend_d = 1'b0;
          if (!w_full) begin
            stack_pc_d[w_push_idx] = pend_pc_q;
            stack_fl_d[w_push_idx] = pend_fl_q;
            depth_d                = depth_q + DW'(1);
            state_d                = ST_SAVE_PC;
          end else begin
            ctx_err_d = 1'b1;
          end
        end else if (iret_pend_q) begin
          iret_pend_d = 1'b0;
          if (!w_empty) begin
            flag_out_d = stack_fl_q[w_top_idx];
            ret_pc_d   = stack_pc_q[w_top_idx];
            depth_d    = depth_q - DW'(1);
            state_d    = ST_RESTORE;
          end else begin
            ctx_err_d = 1'b1;
          end
        end
      end
      // Save states write from the stack top, not the pending capture, which
      // may already hold a newer interrupt's context.
      ST_SAVE_PC: begin
        w_fsm_we   = 1'b1;
        w_fsm_addr = AW'(EPC_IDX);
        w_fsm_data = stack_pc_q[w_top_idx];
        state_d    = ST_SAVE_FL;
      end
      ST_SAVE_FL: begin
        w_fsm_we   = 1'b1;
        w_fsm_addr = AW'(FLAGS_IDX);
        w_fsm_data = DATA_W'(stack_fl_q[w_top_idx]);
        state_d    = ST_IDLE;
      end
      ST_RESTORE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (interrupt) begin
      if (int_pend_q) begin
        ctx_err_d = 1'b1;
      end else begin
        int_pend_d = 1'b1;
        pend_pc_d  = pc_EX;
        pend_fl_d  = flags;
      end
    end
    if (Iret) begin
      if (iret_pend_q) begin
        ctx_err_d = 1'b1;
      end else begin
        iret_pend_d = 1'b1;
      end
    end
  end

  // Single effective write port: FSM saves take precedence over writeback.
  always_comb begin
    w_we    = w_fsm_we || (isWb && !wb_stall);
    w_waddr = w_fsm_we ? w_fsm_addr : rd_ra;
    w_wdata = w_fsm_we ? w_fsm_data : data;
`ifdef REGFILE_R0_ZERO_EN
    if (w_waddr == '0) begin
      w_we = 1'b0;
    end
`endif
    regs_d = regs_q;
    if (w_we) begin
      regs_d[w_waddr] = w_wdata;
    end
  end

  always_comb begin
    rd = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (w_we && (w_waddr == rs[k*AW +: AW])) begin
        rd[k*DATA_W +: DATA_W] = w_wdata;
      end else begin
        rd[k*DATA_W +: DATA_W] = regs_q[rs[k*AW +: AW]];
      end
`ifdef REGFILE_R0_ZERO_EN
      if (rs[k*AW +: AW] == '0) begin
        rd[k*DATA_W +: DATA_W] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      depth_q     <= '0;
      int_pend_q  <= 1'b0;
      iret_pend_q <= 1'b0;
      pend_pc_q   <= '0;
      pend_fl_q   <= '0;
      flag_out_q  <= '0;
      ret_pc_q    <= '0;
      ctx_err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end
      for (int j = 0; j < CTX_DEPTH; j++) begin
        stack_pc_q[j] <= '0;
        stack_fl_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      int_pend_q  <= int_pend_d;
      iret_pend_q <= iret_pend_d;
      pend_pc_q   <= pend_pc_d;
      pend_fl_q   <= pend_fl_d;
      flag_out_q  <= flag_out_d;
      ret_pc_q    <= ret_pc_d;
      ctx_err_q   <= ctx_err_d;
      regs_q      <= regs_d;
      stack_pc_q  <= stack_pc_d;
      stack_fl_q  <= stack_fl_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_ctx_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_ctx_stack
// Brief    : Directed and randomized checks of regfile_ctx_stack against a
//            register-array / context-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_regfile_ctx_stack;

  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 16;
  localparam int NUM_RD    = 2;
  localparam int CTX_DEPTH = 4;
  localparam int EPC_IDX   = 12;
  localparam int FLAGS_IDX = 13;
  localparam int SP_IDX    = 14;
  localparam int SP_RESET  = 25;
  localparam int AW        = 4;
  localparam int DW        = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*AW-1:0]     rs;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [AW-1:0]            rd_ra;
  logic                     isWb;
  logic [DATA_W-1:0]        data;
  logic                     wb_stall;
  logic                     interrupt;
  logic [DATA_W-1:0]        pc_EX;
  logic [1:0]               flags;
  logic                     Iret;
  logic                     int_ack;
  logic                     iret_ack;
  logic [1:0]               flag_out;
  logic [DATA_W-1:0]        ret_pc;
  logic [DW-1:0]            ctx_depth;
  logic                     ctx_err;

  regfile_ctx_stack dut (
    .clk(clk), .rst(rst), .rs(rs), .rd(rd), .rd_ra(rd_ra), .isWb(isWb),
    .data(data), .wb_stall(wb_stall), .interrupt(interrupt), .pc_EX(pc_EX),
    .flags(flags), .Iret(Iret), .int_ack(int_ack), .iret_ack(iret_ack),
    .flag_out(flag_out), .ret_pc(ret_pc), .ctx_depth(ctx_depth), .ctx_err(ctx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  fl;
  } ctx_t;

  int          checks = 0;
  int          errors = 0;
  ctx_t        stk[$];
  logic [31:0] mregs [NUM_REGS];
  logic        merr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mreset();
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = (i == SP_IDX) ? 32'(SP_RESET) : 32'd0;
    stk.delete();
    merr = 1'b0;
  endtask

  function automatic logic [31:0] mread(input int a);
`ifdef REGFILE_R0_ZERO_EN
    if (a == 0) return 32'd0;
`endif
    return mregs[a];
  endfunction

  task automatic mwrite(input int a, input logic [31:0] d);
`ifdef REGFILE_R0_ZERO_EN
    if (a == 0) return;
`endif
    mregs[a] = d;
  endtask

  // Expected read of address a in the current cycle, honouring write-first bypass.
  function automatic logic [31:0] rd_exp(input int a);
    if (isWb && (int'(rd_ra) == a)) begin
`ifdef REGFILE_R0_ZERO_EN
      if (a == 0) return 32'd0;
`endif
      return data;
    end
    return mread(a);
  endfunction

  task automatic do_int(input logic [31:0] pc, input logic [1:0] fl);
    bit ok;
    ok = (stk.size() < CTX_DEPTH);
    rs = {4'(FLAGS_IDX), 4'(EPC_IDX)};
    interrupt = 1'b1; pc_EX = pc; flags = fl;
    cyc();
    interrupt = 1'b0; pc_EX = $urandom; flags = 2'($urandom);
    #1 chk("int_c1_stall", wb_stall, 0);
    chk("int_c1_ack", int_ack, 0);
    cyc(); #1 chk("int_c2_stall", wb_stall, ok);
    cyc(); #1 chk("int_c3_stall", wb_stall, ok);
    chk("int_c3_ack", int_ack, ok);
    if (ok) begin
      chk("int_c3_epc", rd[31:0], pc);
      chk("int_c3_flags_bypass", rd[63:32], {30'd0, fl});
      stk.push_back('{pc: pc, fl: fl});
      mwrite(EPC_IDX, pc);
      mwrite(FLAGS_IDX, {30'd0, fl});
    end else begin
      merr = 1'b1;
      chk("int_full_err", ctx_err, 1);
    end
    cyc(); #1 chk("int_c4_ack", int_ack, 0);
    chk("int_c4_stall", wb_stall, 0);
    chk("int_depth", ctx_depth, stk.size());
    chk("int_err", ctx_err, merr);
    chk("int_reg_epc", rd[31:0], mread(EPC_IDX));
    chk("int_reg_flags", rd[63:32], mread(FLAGS_IDX));
  endtask

  task automatic do_iret();
    bit   ok;
    ctx_t e;
    ok = (stk.size() > 0);
    Iret = 1'b1;
    cyc();
    Iret = 1'b0;
    #1 chk("iret_c1_ack", iret_ack, 0);
    cyc(); #1 chk("iret_c2_ack", iret_ack, ok);
    if (ok) begin
      e = stk.pop_back();
      chk("iret_ret_pc", ret_pc, e.pc);
      chk("iret_flag_out", flag_out, e.fl);
      chk("iret_depth", ctx_depth, stk.size());
    end else begin
      merr = 1'b1;
    end
    chk("iret_err", ctx_err, merr);
    cyc(); #1 chk("iret_c3_ack", iret_ack, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [1:0]  f;
    int          a;
    int          d0;

    rst = 1'b1; rs = '0; rd_ra = '0; isWb = 1'b0; data = '0;
    interrupt = 1'b0; pc_EX = '0; flags = '0; Iret = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    mreset();

    // Reset state
    rs = {4'd14, 4'd3};
    #1 chk("rst_rd1_sp", rd[63:32], 32'(SP_RESET));
    chk("rst_rd0", rd[31:0], 0);
    chk("rst_stall", wb_stall, 0);
    chk("rst_int_ack", int_ack, 0);
    chk("rst_iret_ack", iret_ack, 0);
    chk("rst_flag_out", flag_out, 0);
    chk("rst_ret_pc", ret_pc, 0);
    chk("rst_depth", ctx_depth, 0);
    chk("rst_err", ctx_err, 0);

    // Write-first bypass
    isWb = 1'b1; rd_ra = 4'd3; data = 32'd7; rs = {4'd14, 4'd3};
    #1 chk("byp_same_cycle", rd[31:0], 7);
    cyc();
    mwrite(3, 32'd7);
    isWb = 1'b0;
    #1 chk("byp_after", rd[31:0], mread(3));

    // Random writeback traffic
    for (int n = 0; n < 40; n++) begin
      isWb  = 1'($urandom_range(0, 1));
      rd_ra = 4'($urandom_range(0, NUM_REGS - 1));
      data  = $urandom;
      rs    = 8'($urandom);
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        a = int'(rs[k*AW +: AW]);
        chk($sformatf("rand_rd%0d_a%0d", k, a), rd[k*DATA_W +: DATA_W], rd_exp(a));
      end
      cyc();
      if (isWb) mwrite(int'(rd_ra), data);
    end
    isWb = 1'b0;

    // Nested interrupts and returns
    do_int(32'h40, 2'b10);
    do_int(32'h80, 2'b01);
    do_iret();
    do_iret();

    // Random interrupt / return sequence, never over- or under-flowing
    for (int n = 0; n < 10; n++) begin
      if (stk.size() == 0 || (stk.size() < CTX_DEPTH && $urandom_range(0, 1) == 1)) begin
        do_int($urandom, 2'($urandom));
      end else begin
        do_iret();
      end
    end
    while (stk.size() > 0) do_iret();
    chk("rand_no_err", ctx_err, 0);

    // Simultaneous interrupt and return at depth 1
    do_int($urandom, 2'($urandom));
    v = $urandom; f = 2'($urandom);
    d0 = stk.size();
    interrupt = 1'b1; Iret = 1'b1; pc_EX = v; flags = f;
    cyc();
    interrupt = 1'b0; Iret = 1'b0;
    cyc(); cyc();
    #1 chk("sim_int_ack", int_ack, 1);
    chk("sim_iret_ack_early", iret_ack, 0);
    chk("sim_depth_push", ctx_depth, d0 + 1);
    mwrite(EPC_IDX, v);
    mwrite(FLAGS_IDX, {30'd0, f});
    cyc(); #1 chk("sim_c4_iret_ack", iret_ack, 0);
    cyc(); #1 chk("sim_iret_ack", iret_ack, 1);
    chk("sim_ret_pc", ret_pc, v);
    chk("sim_flag_out", flag_out, f);
    chk("sim_depth_pop", ctx_depth, d0);
    cyc();
    do_iret();

    // Return on an empty stack
    do_iret();
    chk("empty_err_sticky", ctx_err, 1);

    // Overflow: CTX_DEPTH+1 interrupts after a clean reset
    rst = 1'b1; cyc(); rst = 1'b0; mreset();
    for (int n = 0; n < CTX_DEPTH + 1; n++) do_int($urandom, 2'($urandom));
    chk("ovf_depth", ctx_depth, CTX_DEPTH);
    do_iret();

    // Reset during SAVE_PC
    rs = {4'(FLAGS_IDX), 4'(EPC_IDX)};
    interrupt = 1'b1; pc_EX = $urandom | 32'h1; flags = 2'b11;
    cyc();
    interrupt = 1'b0;
    cyc(); #1 chk("rstmid_c2_stall", wb_stall, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; mreset();
    #1 chk("rstmid_stall", wb_stall, 0);
    chk("rstmid_int_ack", int_ack, 0);
    chk("rstmid_depth", ctx_depth, 0);
    chk("rstmid_epc", rd[31:0], mread(EPC_IDX));
    chk("rstmid_err", ctx_err, 0);
    cyc(); #1 chk("rstmid_no_ack", int_ack, 0);
    chk("rstmid_no_stall", wb_stall, 0);

    // Register 0 write and read-back
    isWb = 1'b1; rd_ra = 4'd0; data = $urandom | 32'h1; rs = {4'd14, 4'd0};
    #1 chk("r0_bypass", rd[31:0], rd_exp(0));
    cyc();
    mwrite(0, data);
    isWb = 1'b0;
    #1 chk("r0_readback", rd[31:0], mread(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
